// File: rtl/reg_bank_rz.sv
// reg_bank_rz: eight-entry register bank fed by the RZ destination mux.
// One write port (RZ/DIN/WE), two registered read ports (RX/RY) with
// write-forwarding, and a sequenced bulk clear that zeroes one register
// per cycle while BUSY is high. Rejected writes raise a one-cycle DROP.
module reg_bank_rz #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] RZ,
  input  logic [DATA_W-1:0] DIN,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RX,
  input  logic [ADDR_W-1:0] RY,
  input  logic              CLR,
  output logic [DATA_W-1:0] DOUT_X,
  output logic [DATA_W-1:0] DOUT_Y,
  output logic              BUSY,
  output logic              DROP
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic [DATA_W-1:0]   dout_x_q, dout_x_d;
  logic [DATA_W-1:0]   dout_y_q, dout_y_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;

  logic                wr_accept;
  logic                clr_active;

  // Next-state, register-update and read-data computation.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch can be inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    regs_d     = regs_q;
    wr_accept  = WE && !CLR && (state_q == IDLE);
    clr_active = (state_q == CLEAR);

    // Writes are only legal in IDLE; CLR wins over a same-cycle WE.
    drop_d = WE && (CLR || (state_q == CLEAR));

    // Accepted writes and clear steps never coincide (they need different states).
    if (clr_active) begin
      regs_d[cnt_q] = '0;
    end
    if (wr_accept) begin
      regs_d[RZ] = DIN;
    end

    case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // CLR is ignored here; the sweep always runs to completion.
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // regs_d already holds the post-edge contents, so reading it gives
    // write-forwarding and clear-to-zero for free.
    dout_x_d = regs_d[RX];
    dout_y_d = regs_d[RY];
    busy_d   = (state_d == CLEAR);
  end

  // All state, including the register array, with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dout_x_q <= '0;
      dout_y_q <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      // NOTE: the array is reset deliberately: the bank must read back zero after reset, so it is built from flops, not a RAM macro.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_x_q <= dout_x_d;
      dout_y_q <= dout_y_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign DOUT_X = dout_x_q;
  assign DOUT_Y = dout_y_q;
  assign BUSY   = busy_q;
  assign DROP   = drop_q;

endmodule
